// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding for the serial pattern detector
package seq_det_pkg;

  // Detector control states; the unused code 2'b11 is steered back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - programmable serial bit-pattern detector with saturating match counter
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter int               MEALY   = 1,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1011)
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             en,
  input  logic             in_valid,
  input  logic             In,
  input  logic             overlap,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic             clr_cnt,
  output logic             Out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             busy
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t              state, state_nx;
  logic [PAT_W-1:0]    hist, hist_nx, shifted;
  logic [PAT_W-1:0]    pat_q, pat_nx;
  logic [FILL_W-1:0]   fill, fill_nx;
  logic                acc, hit, out_q;

  // State, history, fill level, pattern and registered match pulse.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      hist  <= '0;
      fill  <= '0;
      pat_q <= RST_PAT;
      out_q <= 1'b0;
    end else begin
      state <= state_nx;
      hist  <= hist_nx;
      fill  <= fill_nx;
      pat_q <= pat_nx;
      out_q <= hit;
    end
  end

  // Next-state, history shift and match detection; a pattern load discards the bit of that cycle.
  always_comb begin
    acc      = en & in_valid & ~cfg_load;
    shifted  = {hist[PAT_W-2:0], In};
    hit      = acc && (fill >= FILL_LAST) && (shifted == pat_q);
    hist_nx  = hist;
    fill_nx  = fill;
    pat_nx   = pat_q;
    state_nx = state;

    if (cfg_load) begin
      pat_nx   = cfg_pat;
      hist_nx  = '0;
      fill_nx  = '0;
      state_nx = en ? FILL : IDLE;
    end else begin
      if (acc) begin
        hist_nx = shifted;
        if (hit && !overlap)
          fill_nx = '0;
        else if (fill < FILL_FULL)
          fill_nx = fill + FILL_W'(1);
      end

      if (!en) begin
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE:    state_nx = FILL;
          FILL:    state_nx = (fill_nx == FILL_FULL) ? RUN : FILL;
          RUN:     state_nx = (hit && !overlap) ? FILL : RUN;
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // Saturating match counter; a clear request wins over a simultaneous hit.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (hit && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + CNT_W'(1);
      if (match_cnt == (CNT_MAX - CNT_W'(1)))
        cnt_sat <= 1'b1;
    end
  end

  assign Out  = (MEALY != 0) ? hit : out_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - scoreboard bench for seq_detector in Mealy and Moore builds
module tb_seq_detector;

  logic       clock = 1'b0;
  logic       reset_b;
  logic       en, in_valid, in_bit, overlap, cfg_load, clr_cnt;
  logic [3:0] cfg_pat;

  logic       out_m, sat_m, busy_m;
  logic       out_r, sat_r, busy_r;
  logic [1:0] cnt_m, cnt_r;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Expected cycle numbers of Out pulses for each build.
  int q_m[$];
  int q_r[$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  seq_detector #(.PAT_W(4), .CNT_W(2), .MEALY(1), .RST_PAT(4'b1011)) dut_m (
    .clock(clock), .reset_b(reset_b), .en(en), .in_valid(in_valid), .In(in_bit),
    .overlap(overlap), .cfg_load(cfg_load), .cfg_pat(cfg_pat), .clr_cnt(clr_cnt),
    .Out(out_m), .match_cnt(cnt_m), .cnt_sat(sat_m), .busy(busy_m)
  );

  seq_detector #(.PAT_W(4), .CNT_W(2), .MEALY(0), .RST_PAT(4'b1011)) dut_r (
    .clock(clock), .reset_b(reset_b), .en(en), .in_valid(in_valid), .In(in_bit),
    .overlap(overlap), .cfg_load(cfg_load), .cfg_pat(cfg_pat), .clr_cnt(clr_cnt),
    .Out(out_r), .match_cnt(cnt_r), .cnt_sat(sat_r), .busy(busy_r)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every Out pulse must match the oldest expected pulse cycle.
  always @(negedge clock) begin
    if (out_m === 1'b1) begin
      if (q_m.size() == 0) check("mealy_unexpected_out", cyc, -1);
      else check("mealy_out_cycle", cyc, q_m.pop_front());
    end
    if (out_r === 1'b1) begin
      if (q_r.size() == 0) check("moore_unexpected_out", cyc, -1);
      else check("moore_out_cycle", cyc, q_r.pop_front());
    end
  end

  task automatic apply_bit(input logic b, input logic exp_hit, input logic clr);
    @(posedge clock); #1;
    in_valid = 1'b1; in_bit = b; cfg_load = 1'b0; clr_cnt = clr;
    if (exp_hit) begin
      q_m.push_back(cyc);
      q_r.push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      in_valid = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0;
    end
  endtask

  task automatic load_pat(input logic [3:0] p);
    @(posedge clock); #1;
    in_valid = 1'b0; cfg_load = 1'b1; cfg_pat = p; clr_cnt = 1'b1;
    idle(1);
  endtask

  task automatic check_cnt(input string name, input int c, input int s);
    check({name, "_cnt_m"}, cnt_m, c);
    check({name, "_cnt_r"}, cnt_r, c);
    check({name, "_sat_m"}, sat_m, s);
    check({name, "_sat_r"}, sat_r, s);
  endtask

  // Stream 1,0,1,1,0,1,1 with hit flags for overlapping and non-overlapping modes.
  logic [6:0] stream   = 7'b1011011;
  logic [6:0] hits_ov  = 7'b0001001;
  logic [6:0] hits_nov = 7'b0001000;
  logic [3:0] p1011    = 4'b1011;

  initial begin
    reset_b = 1'b0; en = 1'b0; in_valid = 1'b0; in_bit = 1'b0; overlap = 1'b1;
    cfg_load = 1'b0; cfg_pat = 4'b0000; clr_cnt = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_out_m", out_m, 0);
    check("reset_out_r", out_r, 0);
    check("reset_busy_m", busy_m, 0);
    check_cnt("reset", 0, 0);
    reset_b = 1'b1;
    en = 1'b1;
    idle(2);
    check("busy_after_en", busy_m, 1);

    // Overlapping matches on bits 4 and 7.
    for (int i = 6; i >= 0; i--) apply_bit(stream[i], hits_ov[i], 1'b0);
    idle(2);
    check_cnt("overlap", 2, 0);

    // Non-overlapping: only bit 4 matches.
    load_pat(p1011);
    overlap = 1'b0;
    for (int i = 6; i >= 0; i--) apply_bit(stream[i], hits_nov[i], 1'b0);
    idle(2);
    check_cnt("nonoverlap", 1, 0);
    check("nonoverlap_busy", busy_m, 1);

    // Gaps between valid bits do not break a match.
    load_pat(p1011);
    overlap = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      apply_bit(p1011[i], i == 0, 1'b0);
      idle(3);
    end
    check_cnt("gaps", 1, 0);

    // Saturation: five overlapping matches, clear on the fifth.
    load_pat(p1011);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) apply_bit(1'b1, 1'b0, 1'b0);
      apply_bit(1'b0, 1'b0, 1'b0);
      apply_bit(1'b1, 1'b0, 1'b0);
      apply_bit(1'b1, 1'b1, 1'b0);
    end
    idle(1);
    check_cnt("sat_third", 3, 1);
    apply_bit(1'b0, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b1, 1'b0);
    idle(1);
    check_cnt("sat_fourth", 3, 1);
    apply_bit(1'b0, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b1, 1'b1);
    idle(2);
    check_cnt("clr_on_hit", 0, 0);

    // Pattern reload mid-stream: the load-cycle bit is discarded, 0110 found on the last bit.
    load_pat(p1011);
    apply_bit(1'b1, 1'b0, 1'b0);
    apply_bit(1'b0, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b0, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b1; in_bit = 1'b1; cfg_load = 1'b1; cfg_pat = 4'b0110;
    apply_bit(1'b1, 1'b0, 1'b0);
    apply_bit(1'b0, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b0, 1'b0);
    apply_bit(1'b0, 1'b1, 1'b0);
    idle(2);
    check_cnt("reload", 1, 0);

    // Asynchronous reset mid-stream restores pattern 1011 and empties the history.
    apply_bit(1'b1, 1'b0, 1'b0);
    apply_bit(1'b0, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b0, 1'b0);
    idle(1);
    #2;
    reset_b = 1'b0;
    #1;
    check("inreset_out_m", out_m, 0);
    check("inreset_out_r", out_r, 0);
    check("inreset_busy_m", busy_m, 0);
    check("inreset_busy_r", busy_r, 0);
    check_cnt("inreset", 0, 0);
    @(posedge clock); #1;
    reset_b = 1'b1;
    apply_bit(1'b1, 1'b0, 1'b0);
    apply_bit(1'b0, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b0, 1'b0);
    apply_bit(1'b1, 1'b1, 1'b0);
    idle(2);
    check_cnt("after_reset", 1, 0);

    // Disable returns the controller to IDLE.
    en = 1'b0;
    idle(2);
    check("disable_busy_m", busy_m, 0);
    check("disable_busy_r", busy_r, 0);

    check("mealy_pending", q_m.size(), 0);
    check("moore_pending", q_r.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
